text_writer: RTL and testbench

Write-side SDRAM client for the text page that the video controller scans out. It accepts cell-write and row-fill commands from the terminal logic and queues them in a small FIFO. Each command is translated into a linear 32-bit word address, honouring the scrolling origin (first_row) and the page wrap (base_address, PAGE_SIZE). Each command is then issued as one SDRAM write burst of a constant charattr word.

---
 rtl/text_writer_pkg.sv | 28 ++
 rtl/text_writer_fifo.sv | 44 ++++
 rtl/text_writer.sv | 153 +++++++++++++++
 tb/tb_text_writer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/text_writer_pkg.sv
// Shared constants, FSM encoding and queued command layout for the text-page writer.
// FILL support is compiled in only when TEXT_WRITER_FILL_EN is defined.
package text_writer_pkg;

  localparam int unsigned Columns   = 80;
  localparam int unsigned Rows      = 51;
  localparam int unsigned RowSize   = 80;
  localparam int unsigned PageSize  = RowSize * Rows;
  localparam int unsigned FifoDepth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StReq,
    StData
  } state_e;

  typedef struct packed {
    logic        fill;
    logic [5:0]  row;
    logic [6:0]  col;
    logic [6:0]  count;
    logic [31:0] data;
  } cmd_t;

  localparam int unsigned CmdWidth = $bits(cmd_t);

endpackage

// File: rtl/text_writer_fifo.sv
// Synchronous command FIFO; pushes while full and pops while empty are ignored.
module text_writer_fifo #(
  parameter int unsigned Width = 53,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             push_en, pop_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + (AddrW+1)'(1);
      if (pop_en)  rptr_q <= rptr_q + (AddrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/text_writer.sv
// SDRAM write client for the scanned-out text page: queues cell/fill commands and issues
// one constant-data burst each. Define TEXT_WRITER_FILL_EN to enable multi-cell FILL.
module text_writer
  import text_writer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_fill_i,
  input  logic [5:0]  cmd_row_i,
  input  logic [6:0]  cmd_col_i,
  input  logic [6:0]  cmd_count_i,
  input  logic [31:0] cmd_data_i,
  input  logic [22:0] base_address_i,
  input  logic [22:0] first_row_i,
  output logic        wr_request_o,
  output logic [22:0] wr_address_o,
  output logic [8:0]  wr_burst_length_o,
  output logic [31:0] wr_data_o,
  input  logic        wr_next_i,
  output logic        busy_o,
  output logic        err_o
);

  state_e      state_q, state_d;
  cmd_t        cmd_in, fifo_rdata, cmd_q;
  logic        fifo_full, fifo_empty, pop;
  logic        load, bad;
  logic [8:0]  len;
  logic [8:0]  cnt_q, cnt_d;
  logic [22:0] addr_q;
  logic [8:0]  len_q;
  logic [31:0] data_q;
  logic [23:0] addr_raw, page_end, addr_wrap;

  assign cmd_in = '{fill:  cmd_fill_i,
                    row:   cmd_row_i,
                    col:   cmd_col_i,
                    count: cmd_count_i,
                    data:  cmd_data_i};

  text_writer_fifo #(
    .Width (CmdWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_valid_i),
    .wdata_i (cmd_in),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Linear address from the scroll origin, folded back once at the end of the page.
  always_comb begin
    addr_raw  = {1'b0, first_row_i} + 24'(cmd_q.row) * 24'(RowSize) + 24'(cmd_q.col);
    page_end  = {1'b0, base_address_i} + 24'(PageSize);
    addr_wrap = (addr_raw >= page_end) ? addr_raw - 24'(PageSize) : addr_raw;
  end

  logic unused_addr_msb;
  assign unused_addr_msb = addr_wrap[23];

`ifdef TEXT_WRITER_FILL_EN
  logic [7:0] room;

  always_comb begin
    room = 8'(Columns) - 8'(cmd_q.col);
    bad  = (cmd_q.row >= 6'(Rows)) || (cmd_q.col >= 7'(Columns)) ||
           (cmd_q.fill && (cmd_q.count == 7'd0));
    len  = 9'd1;
    if (cmd_q.fill) begin
      // Clip so a fill never spills into the following row.
      len = (8'(cmd_q.count) < room) ? 9'(cmd_q.count) : 9'(room);
    end
  end
`else
  logic unused_fill;
  assign unused_fill = ^{cmd_q.fill, cmd_q.count};

  always_comb begin
    bad = (cmd_q.row >= 6'(Rows)) || (cmd_q.col >= 7'(Columns));
    len = 9'd1;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    load    = 1'b0;
    err_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (bad) begin
          err_o   = 1'b1;
          state_d = StIdle;
        end else begin
          load    = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d   = len_q;
        state_d = StData;
      end
      StData: begin
        if (wr_next_i) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) cmd_q <= fifo_rdata;
      if (load) begin
        addr_q <= addr_wrap[22:0];
        len_q  <= len;
        data_q <= cmd_q.data;
      end
    end
  end

  assign cmd_ready_o       = !fifo_full;
  assign wr_request_o      = (state_q == StReq);
  assign wr_address_o      = addr_q;
  assign wr_burst_length_o = len_q;
  assign wr_data_o         = data_q;
  assign busy_o            = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: directed commands push expected bursts/errors,
// a negedge monitor pops and compares them and also acts as the SDRAM wr_next source.
module tb_text_writer;

`ifdef TEXT_WRITER_FILL_EN
  localparam bit FillOn = 1'b1;
`else
  localparam bit FillOn = 1'b0;
`endif

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_fill;
  logic [5:0]  cmd_row;
  logic [6:0]  cmd_col, cmd_count;
  logic [31:0] cmd_data;
  logic [22:0] base_address, first_row;
  logic        wr_request, wr_next, busy, err;
  logic [22:0] wr_address;
  logic [8:0]  wr_burst_length;
  logic [31:0] wr_data;

  text_writer dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .cmd_valid_i       (cmd_valid),
    .cmd_ready_o       (cmd_ready),
    .cmd_fill_i        (cmd_fill),
    .cmd_row_i         (cmd_row),
    .cmd_col_i         (cmd_col),
    .cmd_count_i       (cmd_count),
    .cmd_data_i        (cmd_data),
    .base_address_i    (base_address),
    .first_row_i       (first_row),
    .wr_request_o      (wr_request),
    .wr_address_o      (wr_address),
    .wr_burst_length_o (wr_burst_length),
    .wr_data_o         (wr_data),
    .wr_next_i         (wr_next),
    .busy_o            (busy),
    .err_o             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] addr;
    logic [8:0]  len;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   err_q[$];
  exp_t hold;
  int   vectors, miscompares;
  int   rem, len_lat, req_count;
  bit   load_pend, next_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor plus SDRAM model: wr_next is raised only once the DUT has left REQ.
  always @(negedge clk) begin
    if (!rst_n) begin
      rem       = 0;
      load_pend = 1'b0;
      wr_next   = 1'b0;
    end else begin
      if (wr_next) rem--;
      if (load_pend) begin
        rem       = len_lat;
        load_pend = 1'b0;
      end
      if (rem > 0) begin
        chk("busy_during_burst", busy, 1'b1);
        chk("addr_hold", wr_address, hold.addr);
        chk("len_hold", wr_burst_length, hold.len);
        chk("data_hold", wr_data, hold.data);
      end
      if (wr_request) begin
        exp_t e;
        req_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_request", wr_address, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_address", wr_address, e.addr);
          chk("wr_burst_length", wr_burst_length, e.len);
          chk("wr_data", wr_data, e.data);
        end
        hold      = '{wr_address, wr_burst_length, wr_data};
        len_lat   = int'(wr_burst_length);
        load_pend = 1'b1;
      end
      if (err) begin
        if (err_q.size() == 0) chk("unexpected_err", err, 1'b0);
        else begin
          void'(err_q.pop_front());
          chk("err_pulse", err, 1'b1);
        end
      end
      wr_next = next_en && (rem > 0);
    end
  end

  task automatic push(input bit fill, input int row, input int col, input int count,
                      input logic [31:0] data, input bit exp_err, input logic [22:0] ea,
                      input int el);
    int guard;
    bit rdy;
    guard = 0;
    if (exp_err) err_q.push_back(1'b1);
    else exp_q.push_back('{ea, 9'(el), data});
    cmd_fill  = fill;
    cmd_row   = 6'(row);
    cmd_col   = 7'(col);
    cmd_count = 7'(count);
    cmd_data  = data;
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 200);
    if (!rdy) chk("push_timeout", rdy, 1'b1);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((exp_q.size() != 0 || err_q.size() != 0 || busy || rem != 0) && guard < 600);
    chk({name, "_pending"}, exp_q.size() + err_q.size(), 0);
    chk({name, "_idle"}, busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_wr_request"}, wr_request, 1'b0);
    chk({tag, "_wr_address"}, wr_address, 0);
    chk({tag, "_wr_burst_length"}, wr_burst_length, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    int rc;
    vectors = 0; miscompares = 0; req_count = 0; rem = 0;
    next_en = 1'b1; load_pend = 1'b0; wr_next = 1'b0;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_fill = 1'b0; cmd_row = '0; cmd_col = '0;
    cmd_count = '0; cmd_data = '0; base_address = '0; first_row = '0;
    #2 rst_n = 1'b0;
    #10 chk_reset_values("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic cell write.
    push(1'b0, 2, 5, 0, 32'hA5A5_0041, 1'b0, 23'h0A5, 1);
    drain("basic");

    // Page wrap: 0xF00 + 50*80 + 3 - 0xFF0.
    first_row = 23'h000F00;
    push(1'b0, 50, 3, 0, 32'h1111_0002, 1'b0, 23'h000EB3, 1);
    drain("wrap");

    // Page end at 0x1FF0: one below, exactly at, and past it.
    base_address = 23'h001000;
    first_row    = 23'h001FE0;
    push(1'b0, 0, 15, 0, 32'h2222_0003, 1'b0, 23'h001FEF, 1);
    push(1'b0, 0, 16, 0, 32'h2222_0004, 1'b0, 23'h001000, 1);
    push(1'b0, 0, 20, 0, 32'h2222_0005, 1'b0, 23'h001004, 1);
    drain("wrap_boundary");

    // Fill clipping at end of row, full row, last cell.
    base_address = '0;
    first_row    = '0;
    push(1'b1, 0, 70, 20, 32'h3333_0006, 1'b0, 23'h000046, FillOn ? 10 : 1);
    push(1'b1, 3, 0, 80, 32'h3333_0007, 1'b0, 23'h0000F0, FillOn ? 80 : 1);
    push(1'b1, 4, 79, 1, 32'h3333_0008, 1'b0, 23'h00018F, 1);
    drain("fill");

    // Drops, then a good command behind them.
    push(1'b0, 51, 0, 0, 32'h4444_0009, 1'b1, '0, 0);
    push(1'b0, 0, 80, 0, 32'h4444_000A, 1'b1, '0, 0);
    push(1'b1, 0, 0, 0, 32'h4444_000B, FillOn, 23'h000000, 1);
    push(1'b0, 1, 0, 0, 32'h4444_000C, 1'b0, 23'h000050, 1);
    drain("drops");

    // Backpressure: first command parks in DATA, next four fill the FIFO.
    first_row = 23'h000100;
    next_en   = 1'b0;
    push(1'b0, 3, 1, 0, 32'h5555_0001, 1'b0, 23'h0001F1, 1);
    push(1'b0, 4, 2, 0, 32'h5555_0002, 1'b0, 23'h000242, 1);
    push(1'b0, 5, 3, 0, 32'h5555_0003, 1'b0, 23'h000293, 1);
    push(1'b0, 6, 4, 0, 32'h5555_0004, 1'b0, 23'h0002E4, 1);
    push(1'b0, 7, 5, 0, 32'h5555_0005, 1'b0, 23'h000335, 1);
    @(negedge clk);
    chk("bp_cmd_ready_full", cmd_ready, 1'b0);
    chk("bp_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    chk("bp_cmd_ready_still_full", cmd_ready, 1'b0);
    next_en = 1'b1;
    drain("backpressure");
    chk("bp_cmd_ready_after", cmd_ready, 1'b1);

    // Reset mid-burst with two commands queued.
    first_row = '0;
    next_en   = 1'b0;
    push(1'b0, 0, 1, 0, 32'h6666_0001, 1'b0, 23'h000001, 1);
    push(1'b0, 0, 2, 0, 32'h6666_0002, 1'b0, 23'h000002, 1);
    push(1'b0, 0, 3, 0, 32'h6666_0003, 1'b0, 23'h000003, 1);
    repeat (5) @(posedge clk);
    chk("rst_busy_before", busy, 1'b1);
    exp_q.delete();
    #3 rst_n = 1'b0;
    #1 chk_reset_values("midburst_reset");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_en = 1'b1;
    rc = req_count;
    repeat (20) @(negedge clk);
    chk("no_request_after_reset", req_count, rc);
    chk("idle_after_reset", busy, 1'b0);
    @(posedge clk);
    #1;

    // Normal operation resumes.
    push(1'b0, 2, 5, 0, 32'h7777_0001, 1'b0, 23'h0000A5, 1);
    drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
